// File: rtl/sisc_exec_ctrl_pkg.sv
// Shared encodings for the SISC execution controller: opcodes, ALU functs,
// FSM states, operand/writeback/load selects and status bit positions.
package sisc_exec_ctrl_pkg;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_ALU_R = 4'd1;
   localparam logic [3:0] OP_ALU_I = 4'd2;
   localparam logic [3:0] OP_BRA   = 4'd4;
   localparam logic [3:0] OP_BRR   = 4'd5;
   localparam logic [3:0] OP_BNE   = 4'd6;
   localparam logic [3:0] OP_BNR   = 4'd7;
   localparam logic [3:0] OP_LOD   = 4'd8;
   localparam logic [3:0] OP_STR   = 4'd9;
   localparam logic [3:0] OP_HLT   = 4'd15;

   localparam logic [3:0] FN_ADD  = 4'd0;
   localparam logic [3:0] FN_SUB  = 4'd1;
   localparam logic [3:0] FN_AND  = 4'd2;
   localparam logic [3:0] FN_OR   = 4'd3;
   localparam logic [3:0] FN_XOR  = 4'd4;
   localparam logic [3:0] FN_NOT  = 4'd5;
   localparam logic [3:0] FN_SHL  = 4'd6;
   localparam logic [3:0] FN_SHR  = 4'd7;
   localparam logic [3:0] FN_ROTL = 4'd8;
   localparam logic [3:0] FN_ROTR = 4'd9;

   // Operand-B select driven on alu_op.
   localparam logic [1:0] AOP_RR    = 2'b00;
   localparam logic [1:0] AOP_ZEXT  = 2'b01;
   localparam logic [1:0] AOP_SEXT  = 2'b10;
   localparam logic [1:0] AOP_PASSB = 2'b11;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] LS_ALU = 2'b00;

   localparam int ST_C = 3;
   localparam int ST_V = 2;
   localparam int ST_N = 1;
   localparam int ST_Z = 0;

   typedef enum logic [2:0] {
      S_START0, S_START1, S_FETCH, S_DECODE,
      S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
   } state_e;

endpackage

// File: rtl/sisc_alu.sv
// Combinational 32-bit ALU with {C,V,N,Z} flags; zero latency, no flow control.
// alu_op picks operand B; the sign-extended form forces ADD for address generation.
module sisc_alu
   import sisc_exec_ctrl_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b_reg,
   input  logic [15:0] i_imm,
   input  logic [3:0]  i_funct,
   input  logic [1:0]  i_alu_op,
   output logic [31:0] o_result,
   output logic [3:0]  o_stat
);

   logic [31:0] w_b;
   logic [3:0]  w_fn;
   logic        w_passb;
   logic [32:0] w_sum;
   logic [32:0] w_diff;
   logic [4:0]  w_sh;
   logic [5:0]  w_rsh;
   logic [31:0] w_res;
   logic        w_c;
   logic        w_v;

   always_comb begin
      w_b     = i_b_reg;
      w_fn    = i_funct;
      w_passb = 1'b0;
      case (i_alu_op)
         AOP_ZEXT:  w_b = {16'h0000, i_imm};
         AOP_SEXT:  begin
            w_b  = {{16{i_imm[15]}}, i_imm};
            w_fn = FN_ADD;
         end
         AOP_PASSB: w_passb = 1'b1;
         default:   ;
      endcase
   end

   // Subtract as A + ~B + 1 so the carry-out is directly NOT borrow.
   assign w_sum  = {1'b0, i_a} + {1'b0, w_b};
   assign w_diff = {1'b0, i_a} + {1'b0, ~w_b} + 33'd1;
   assign w_sh   = w_b[4:0];
   assign w_rsh  = 6'd32 - {1'b0, w_sh};

   always_comb begin
      w_res = i_a;
      w_c   = 1'b0;
      w_v   = 1'b0;
      if (w_passb) begin
         w_res = w_b;
      end else begin
         case (w_fn)
            FN_ADD: begin
               w_res = w_sum[31:0];
               w_c   = w_sum[32];
               w_v   = (i_a[31] == w_b[31]) && (w_sum[31] != i_a[31]);
            end
            FN_SUB: begin
               w_res = w_diff[31:0];
               w_c   = w_diff[32];
               w_v   = (i_a[31] != w_b[31]) && (w_diff[31] != i_a[31]);
            end
            FN_AND:  w_res = i_a & w_b;
            FN_OR:   w_res = i_a | w_b;
            FN_XOR:  w_res = i_a ^ w_b;
            FN_NOT:  w_res = ~i_a;
            FN_SHL:  w_res = i_a << w_sh;
            FN_SHR:  w_res = i_a >> w_sh;
            FN_ROTL: w_res = (i_a << w_sh) | (i_a >> w_rsh);
            FN_ROTR: w_res = (i_a >> w_sh) | (i_a << w_rsh);
            default: w_res = i_a;
         endcase
      end
   end

   assign o_result = w_res;

   always_comb begin
      o_stat       = 4'b0000;
      o_stat[ST_C] = w_c;
      o_stat[ST_V] = w_v;
      o_stat[ST_N] = w_res[31];
      o_stat[ST_Z] = (w_res == 32'h0000_0000);
   end

endmodule

// File: rtl/sisc_exec_ctrl.sv
// SISC multicycle control: 8-state FSM, branch target/condition and ALU instance.
// One state per cycle, no stalls; outputs are a combinational decode of state and ir.
module sisc_exec_ctrl
   import sisc_exec_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_f,
   input  logic [31:0] ir,
   input  logic [31:0] rsa,
   input  logic [31:0] rsb,
   input  logic [3:0]  stat_in,
   input  logic [15:0] pc_inc,
   output logic [31:0] alu_result,
   output logic [3:0]  stat,
   output logic        stat_en,
   output logic [15:0] br_addr,
   output logic        pc_rst,
   output logic        pc_write,
   output logic        pc_sel,
   output logic        ir_load,
   output logic        rf_we,
   output logic        dm_we,
   output logic        rd_sel,
   output logic        wr_sel,
   output logic [1:0]  wb_sel,
   output logic [1:0]  load_sel,
   output logic [1:0]  alu_op
);

   state_e      r_state;
   state_e      w_next_state;
   logic [3:0]  w_op;
   logic [3:0]  w_mm;
   logic        w_hit;
   logic        w_is_alu;
   logic        w_is_lod;
   logic        w_is_str;
   logic        w_br_sel;
   logic        w_taken;
   logic        w_is_hlt;
   logic [1:0]  w_dec_aop;
   logic        w_unused_fields;

   assign w_op  = ir[31:28];
   assign w_mm  = ir[27:24];
   assign w_hit = |(w_mm & stat_in);
   // rd/rs select register-file ports outside this block.
   assign w_unused_fields = ^ir[23:16];

   always_comb begin
      w_is_alu  = 1'b0;
      w_is_lod  = 1'b0;
      w_is_str  = 1'b0;
      w_br_sel  = 1'b0;
      w_taken   = 1'b0;
      w_is_hlt  = 1'b0;
      w_dec_aop = AOP_RR;
      case (w_op)
         OP_NOOP:  ;
         OP_ALU_R: w_is_alu = 1'b1;
         OP_ALU_I: begin w_is_alu = 1'b1; w_dec_aop = AOP_ZEXT; end
         OP_BRA:   begin w_br_sel = 1'b1; w_taken = w_hit;  end
         OP_BRR:   w_taken = w_hit;
         OP_BNE:   begin w_br_sel = 1'b1; w_taken = !w_hit; end
         OP_BNR:   w_taken = !w_hit;
         OP_LOD:   begin w_is_lod = 1'b1; w_dec_aop = AOP_SEXT; end
         OP_STR:   begin w_is_str = 1'b1; w_dec_aop = AOP_SEXT; end
         OP_HLT:   w_is_hlt = 1'b1;
         default:  ;
      endcase
   end

   assign br_addr = w_br_sel ? ir[15:0] : (pc_inc + ir[15:0]);

   sisc_alu u_alu (
      .i_a      (rsa),
      .i_b_reg  (rsb),
      .i_imm    (ir[15:0]),
      .i_funct  (w_mm),
      .i_alu_op (alu_op),
      .o_result (alu_result),
      .o_stat   (stat)
   );

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) r_state <= S_START0;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      pc_rst   = 1'b0;
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      ir_load  = 1'b0;
      rf_we    = 1'b0;
      dm_we    = 1'b0;
      rd_sel   = 1'b0;
      wr_sel   = 1'b0;
      stat_en  = 1'b0;
      wb_sel   = WB_ALU;
      load_sel = LS_ALU;
      alu_op   = AOP_RR;
      case (r_state)
         S_START0: begin
            pc_rst       = 1'b1;
            w_next_state = S_START1;
         end
         S_START1: w_next_state = S_FETCH;
         S_FETCH: begin
            ir_load      = 1'b1;
            pc_write     = 1'b1;
            w_next_state = S_DECODE;
         end
         S_DECODE: begin
            pc_sel       = w_taken;
            pc_write     = w_taken;
            w_next_state = w_is_hlt ? S_HALT : S_EXECUTE;
         end
         S_EXECUTE: begin
            alu_op       = w_dec_aop;
            rd_sel       = w_is_str;
            stat_en      = w_is_alu;
            w_next_state = S_MEM;
         end
         S_MEM: begin
            alu_op       = w_dec_aop;
            rd_sel       = w_is_str;
            dm_we        = w_is_str;
            w_next_state = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            alu_op       = w_dec_aop;
            rd_sel       = w_is_str;
            rf_we        = w_is_alu | w_is_lod;
            wb_sel       = w_is_lod ? WB_MEM : WB_ALU;
            w_next_state = S_FETCH;
         end
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_START0;
      endcase
   end

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// Directed self-checking bench for sisc_exec_ctrl; outputs sampled on the falling edge.
module tb_sisc_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst_f;
   logic [31:0] ir, rsa, rsb;
   logic [3:0]  stat_in;
   logic [15:0] pc_inc;
   logic [31:0] alu_result;
   logic [3:0]  stat;
   logic        stat_en;
   logic [15:0] br_addr;
   logic        pc_rst, pc_write, pc_sel, ir_load, rf_we, dm_we, rd_sel, wr_sel;
   logic [1:0]  wb_sel, load_sel, alu_op;
   logic [14:0] ctrl;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [14:0] K_PCRST = 15'h4000;
   localparam logic [14:0] K_PCW   = 15'h2000;
   localparam logic [14:0] K_PCSEL = 15'h1000;
   localparam logic [14:0] K_IRL   = 15'h0800;
   localparam logic [14:0] K_RFWE  = 15'h0400;
   localparam logic [14:0] K_DMWE  = 15'h0200;
   localparam logic [14:0] K_RDSEL = 15'h0100;
   localparam logic [14:0] K_WBMEM = 15'h0020;
   localparam logic [14:0] K_AOPS  = 15'h0004;
   localparam logic [14:0] K_AOPI  = 15'h0002;
   localparam logic [14:0] K_STEN  = 15'h0001;
   localparam logic [14:0] K_NONE  = 15'h0000;

   typedef struct packed {
      logic [3:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  st;
   } alu_vec_t;

   typedef struct packed {
      logic [31:0] ir;
      logic [3:0]  st;
      logic [15:0] pc;
      logic        taken;
      logic [15:0] addr;
   } br_vec_t;

   always #5 clk = ~clk;

   assign ctrl = {pc_rst, pc_write, pc_sel, ir_load, rf_we, dm_we, rd_sel, wr_sel,
                  wb_sel, load_sel, alu_op, stat_en};

   sisc_exec_ctrl dut (
      .clk(clk), .rst_f(rst_f), .ir(ir), .rsa(rsa), .rsb(rsb),
      .stat_in(stat_in), .pc_inc(pc_inc),
      .alu_result(alu_result), .stat(stat), .stat_en(stat_en), .br_addr(br_addr),
      .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .ir_load(ir_load),
      .rf_we(rf_we), .dm_we(dm_we), .rd_sel(rd_sel), .wr_sel(wr_sel),
      .wb_sel(wb_sel), .load_sel(load_sel), .alu_op(alu_op)
   );

   task automatic reset_dut();
      rst_f = 1'b0;
      repeat (2) @(negedge clk);
      rst_f = 1'b1;
   endtask

   task automatic go_fetch();
      reset_dut();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      ir = 32'h0; rsa = 32'h0; rsb = 32'h0; stat_in = 4'h0; pc_inc = 16'h0;
      rst_f = 1'b1;
      #2 rst_f = 1'b0;
      #1;
      n_tests++; if (ctrl !== K_PCRST) begin n_fail++; $display("FAIL reset_async: ctrl=%h want %h", ctrl, K_PCRST); end
      repeat (2) @(negedge clk);
      n_tests++; if (ctrl !== K_PCRST) begin n_fail++; $display("FAIL reset_hold: ctrl=%h want %h", ctrl, K_PCRST); end
      rst_f = 1'b1;
      #1;
      n_tests++; if (ctrl !== K_PCRST) begin n_fail++; $display("FAIL start0: ctrl=%h want %h", ctrl, K_PCRST); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL start1: ctrl=%h want %h", ctrl, K_NONE); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_IRL | K_PCW)) begin n_fail++; $display("FAIL first_fetch: ctrl=%h want %h", ctrl, K_IRL | K_PCW); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL noop_decode: ctrl=%h want %h", ctrl, K_NONE); end
   endtask

   task automatic test_alu_add();
      ir = 32'h1012_3000; rsa = 32'h7FFF_FFFF; rsb = 32'h0000_0001;
      go_fetch();
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL add_decode: ctrl=%h want %h", ctrl, K_NONE); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_STEN) begin n_fail++; $display("FAIL add_exec_ctrl: ctrl=%h want %h", ctrl, K_STEN); end
      n_tests++; if (alu_result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_result: got %h want 80000000", alu_result); end
      n_tests++; if (stat !== 4'b0110) begin n_fail++; $display("FAIL add_stat: got %b want 0110", stat); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL add_mem: ctrl=%h want %h", ctrl, K_NONE); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_RFWE) begin n_fail++; $display("FAIL add_wb: ctrl=%h want %h", ctrl, K_RFWE); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_IRL | K_PCW)) begin n_fail++; $display("FAIL add_next_fetch: ctrl=%h want %h", ctrl, K_IRL | K_PCW); end
   endtask

   task automatic test_alu_sub();
      ir = 32'h1112_3000; rsa = 32'd5; rsb = 32'd5;
      go_fetch();
      repeat (2) @(negedge clk);
      n_tests++; if (ctrl !== K_STEN) begin n_fail++; $display("FAIL sub_exec_ctrl: ctrl=%h want %h", ctrl, K_STEN); end
      n_tests++; if (alu_result !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h want 0", alu_result); end
      n_tests++; if (stat !== 4'b1001) begin n_fail++; $display("FAIL sub_stat: got %b want 1001", stat); end
      repeat (2) @(negedge clk);
      n_tests++; if (ctrl !== K_RFWE) begin n_fail++; $display("FAIL sub_wb: ctrl=%h want %h", ctrl, K_RFWE); end
   endtask

   // ALU_R keeps alu_op at 00 in every state, so vectors can change each cycle.
   task automatic test_alu_funcs();
      alu_vec_t av[13];
      av[0]  = '{4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 4'b0000};
      av[1]  = '{4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 4'b0010};
      av[2]  = '{4'd4,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0001};
      av[3]  = '{4'd5,  32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 4'b0010};
      av[4]  = '{4'd6,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010, 4'b0000};
      av[5]  = '{4'd7,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000};
      av[6]  = '{4'd8,  32'h8000_0001, 32'h0000_0004, 32'h0000_0018, 4'b0000};
      av[7]  = '{4'd9,  32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 4'b0010};
      av[8]  = '{4'd8,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0000};
      av[9]  = '{4'd12, 32'hDEAD_BEEF, 32'h0000_0001, 32'hDEAD_BEEF, 4'b0010};
      av[10] = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1001};
      av[11] = '{4'd1,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0010};
      av[12] = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100};
      ir = 32'h1000_0000;
      go_fetch();
      for (int i = 0; i < 13; i++) begin
         ir  = {4'h1, av[i].fn, 24'h000000};
         rsa = av[i].a;
         rsb = av[i].b;
         @(negedge clk);
         n_tests++; if (alu_result !== av[i].res) begin n_fail++; $display("FAIL alu_vec%0d_result: got %h want %h", i, alu_result, av[i].res); end
         n_tests++; if (stat !== av[i].st) begin n_fail++; $display("FAIL alu_vec%0d_stat: got %b want %b", i, stat, av[i].st); end
      end
   endtask

   task automatic test_back_to_back();
      ir = 32'h2012_FFFF; rsa = 32'h0000_0010; rsb = 32'hAAAA_AAAA;
      go_fetch();
      repeat (2) @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPI | K_STEN)) begin n_fail++; $display("FAIL addi_exec: ctrl=%h want %h", ctrl, K_AOPI | K_STEN); end
      n_tests++; if (alu_result !== 32'h0001_000F) begin n_fail++; $display("FAIL addi_result: got %h want 0001000f", alu_result); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_AOPI) begin n_fail++; $display("FAIL addi_mem: ctrl=%h want %h", ctrl, K_AOPI); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPI | K_RFWE)) begin n_fail++; $display("FAIL addi_wb: ctrl=%h want %h", ctrl, K_AOPI | K_RFWE); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_IRL | K_PCW)) begin n_fail++; $display("FAIL b2b_fetch: ctrl=%h want %h", ctrl, K_IRL | K_PCW); end
      ir = 32'h3000_0000;
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL undef_op_state%0d: ctrl=%h want %h", s, ctrl, K_NONE); end
      end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_IRL | K_PCW)) begin n_fail++; $display("FAIL b2b_fetch2: ctrl=%h want %h", ctrl, K_IRL | K_PCW); end
   endtask

   task automatic test_str();
      ir = 32'h9312_0004; rsa = 32'h0000_0100; rsb = 32'h0000_0055;
      go_fetch();
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL str_decode: ctrl=%h want %h", ctrl, K_NONE); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPS | K_RDSEL)) begin n_fail++; $display("FAIL str_exec: ctrl=%h want %h", ctrl, K_AOPS | K_RDSEL); end
      n_tests++; if (alu_result !== 32'h0000_0104) begin n_fail++; $display("FAIL str_addr: got %h want 00000104", alu_result); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPS | K_RDSEL | K_DMWE)) begin n_fail++; $display("FAIL str_mem: ctrl=%h want %h", ctrl, K_AOPS | K_RDSEL | K_DMWE); end
      n_tests++; if (alu_result !== 32'h0000_0104) begin n_fail++; $display("FAIL str_mem_addr: got %h want 00000104", alu_result); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPS | K_RDSEL)) begin n_fail++; $display("FAIL str_wb: ctrl=%h want %h", ctrl, K_AOPS | K_RDSEL); end
   endtask

   task automatic test_lod();
      ir = 32'h8012_FFFC; rsa = 32'h0000_0100; rsb = 32'h0;
      go_fetch();
      repeat (2) @(negedge clk);
      n_tests++; if (ctrl !== K_AOPS) begin n_fail++; $display("FAIL lod_exec: ctrl=%h want %h", ctrl, K_AOPS); end
      n_tests++; if (alu_result !== 32'h0000_00FC) begin n_fail++; $display("FAIL lod_addr: got %h want 000000fc", alu_result); end
      @(negedge clk);
      n_tests++; if (ctrl !== K_AOPS) begin n_fail++; $display("FAIL lod_mem: ctrl=%h want %h", ctrl, K_AOPS); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPS | K_RFWE | K_WBMEM)) begin n_fail++; $display("FAIL lod_wb: ctrl=%h want %h", ctrl, K_AOPS | K_RFWE | K_WBMEM); end
   endtask

   task automatic test_branches();
      br_vec_t bv[8];
      logic [14:0] want;
      bv[0] = '{32'h5100_FFFE, 4'b0001, 16'h0010, 1'b1, 16'h000E};
      bv[1] = '{32'h5100_FFFE, 4'b0000, 16'h0010, 1'b0, 16'h000E};
      bv[2] = '{32'h4800_1234, 4'b1000, 16'h5555, 1'b1, 16'h1234};
      bv[3] = '{32'h4800_1234, 4'b0111, 16'h5555, 1'b0, 16'h1234};
      bv[4] = '{32'h6400_0042, 4'b0100, 16'h0100, 1'b0, 16'h0042};
      bv[5] = '{32'h6400_0042, 4'b1011, 16'h0100, 1'b1, 16'h0042};
      bv[6] = '{32'h7F00_0020, 4'b0000, 16'hFFF0, 1'b1, 16'h0010};
      bv[7] = '{32'h7F00_0020, 4'b0010, 16'hFFF0, 1'b0, 16'h0010};
      for (int i = 0; i < 8; i++) begin
         ir = bv[i].ir; stat_in = bv[i].st; pc_inc = bv[i].pc;
         want = bv[i].taken ? (K_PCSEL | K_PCW) : K_NONE;
         go_fetch();
         @(negedge clk);
         n_tests++; if (ctrl !== want) begin n_fail++; $display("FAIL br%0d_decode: ctrl=%h want %h", i, ctrl, want); end
         n_tests++; if (br_addr !== bv[i].addr) begin n_fail++; $display("FAIL br%0d_addr: got %h want %h", i, br_addr, bv[i].addr); end
         @(negedge clk);
         n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL br%0d_exec: ctrl=%h want %h", i, ctrl, K_NONE); end
      end
      stat_in = 4'h0;
   endtask

   task automatic test_halt();
      ir = 32'hF000_0000;
      go_fetch();
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL hlt_decode: ctrl=%h want %h", ctrl, K_NONE); end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL halt_cycle%0d: ctrl=%h want %h", c, ctrl, K_NONE); end
      end
      rst_f = 1'b0;
      #1;
      n_tests++; if (ctrl !== K_PCRST) begin n_fail++; $display("FAIL halt_reset: ctrl=%h want %h", ctrl, K_PCRST); end
      @(negedge clk);
      rst_f = 1'b1;
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL halt_restart_start1: ctrl=%h want %h", ctrl, K_NONE); end
      @(negedge clk);
      n_tests++; if (ctrl !== (K_IRL | K_PCW)) begin n_fail++; $display("FAIL halt_restart_fetch: ctrl=%h want %h", ctrl, K_IRL | K_PCW); end
   endtask

   task automatic test_reset_mid();
      ir = 32'h9312_0004; rsa = 32'h0000_0100;
      go_fetch();
      repeat (3) @(negedge clk);
      n_tests++; if (ctrl !== (K_AOPS | K_RDSEL | K_DMWE)) begin n_fail++; $display("FAIL mid_pre_mem: ctrl=%h want %h", ctrl, K_AOPS | K_RDSEL | K_DMWE); end
      #2 rst_f = 1'b0;
      #1;
      n_tests++; if (ctrl !== K_PCRST) begin n_fail++; $display("FAIL mid_abort: ctrl=%h want %h", ctrl, K_PCRST); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_tests++; if (ctrl !== K_PCRST) begin n_fail++; $display("FAIL mid_hold%0d: ctrl=%h want %h", c, ctrl, K_PCRST); end
      end
      rst_f = 1'b1;
      @(negedge clk);
      n_tests++; if (ctrl !== K_NONE) begin n_fail++; $display("FAIL mid_start1: ctrl=%h want %h", ctrl, K_NONE); end
   endtask

   initial begin
      test_reset();
      test_alu_add();
      test_alu_sub();
      test_alu_funcs();
      test_back_to_back();
      test_str();
      test_lod();
      test_branches();
      test_halt();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
